// File: rtl/sd_dat_writer.sv
// sd_dat_writer: SD 4-bit DAT-line block transmitter.
// Sends start bit, payload nibbles, per-line CRC16 and end bit. It then collects
// the card's CRC-status token on DAT0 and waits out the card's busy period.
// Optional macro SD_DAT_WRITER_BUSY_TIMEOUT_EN adds a busy-period timeout counter.
// Without the macro the writer waits indefinitely for DAT0 to return high.
module sd_dat_writer #(
    parameter int BLOCK_LEN_BYTES   = 512,
    parameter int STATUS_WAIT_CLKS  = 16,
    parameter int BUSY_TIMEOUT_CLKS = 1 << 20
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        blk_start,
    input  logic [15:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [3:0]  sd_dat_out,
    output logic        sd_dat_oe,
    input  logic [3:0]  sd_dat_in,
    output logic        idle,
    output logic        done,
    output logic [2:0]  status,
    output logic        underrun
);

    localparam int WORDS  = BLOCK_LEN_BYTES / 2;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W  = $clog2(STATUS_WAIT_CLKS + 16);

    // Refuse to elaborate with a block length or wait limits the logic cannot honour.
    if ((BLOCK_LEN_BYTES < 2) || (BLOCK_LEN_BYTES % 2 != 0) ||
        (STATUS_WAIT_CLKS < 1) || (BUSY_TIMEOUT_CLKS < 1)) begin : g_bad_params
        $error("sd_dat_writer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_START, S_DATA, S_CRC, S_END, S_STAT, S_BUSY
    } state_t;

    // Sub-phases of the CRC-status token reception.
    typedef enum logic [1:0] {T_WAIT, T_BITS, T_END} tok_ph_t;

    state_t            state;
    tok_ph_t           tok_ph;
    logic [WORD_W-1:0] word_idx;
    logic [1:0]        nib;
    logic [15:0]       shreg;
    logic [3:0][15:0]  crc;
    logic [2:0]        tok;
    logic [CNT_W-1:0]  cnt;
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
    localparam int BUSY_W = $clog2(BUSY_TIMEOUT_CLKS + 1);
    logic [BUSY_W-1:0] busy_cnt;
`endif

    logic             last_word;
    logic             take_word;
    logic [15:0]      in_word;
    logic [3:0]       emit_nib;
    logic [3:0][15:0] crc_nxt;
    logic [3:0][15:0] crc_shl;
    logic [3:0]       crc_msb;
    logic             unused_dat_in;

    // Only DAT0 carries the token and busy signalling.
    assign unused_dat_in = ^sd_dat_in[3:1];

    // One serial CRC16-CCITT step (x^16+x^12+x^5+1).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign last_word = (word_idx == WORD_W'(WORDS - 1));
    assign in_word   = wdata_valid ? wdata : 16'h0000;

    // Select the nibble driven next cycle and the CRC values it produces.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        take_word = 1'b0;
        if (state == S_START)
            take_word = 1'b1;
        else if (state == S_DATA && nib == 2'd3)
            take_word = !last_word;
        emit_nib = take_word ? in_word[15:12] : shreg[15:12];
        for (int i = 0; i < 4; i++) begin
            crc_nxt[i] = crc_step(crc[i], emit_nib[i]);
            crc_shl[i] = {crc[i][14:0], 1'b0};
            crc_msb[i] = crc[i][15];
        end
    end

    // Block sequencer; every output is registered together with the state it belongs to.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            // NOTE: the CRC bank is four plain registers, so it resets like any other flop.
            state       <= S_IDLE;
            tok_ph      <= T_WAIT;
            word_idx    <= '0;
            nib         <= '0;
            shreg       <= '0;
            crc         <= '0;
            tok         <= '0;
            cnt         <= '0;
            wdata_ready <= 1'b0;
            sd_dat_out  <= 4'hF;
            sd_dat_oe   <= 1'b0;
            idle        <= 1'b1;
            done        <= 1'b0;
            status      <= 3'b000;
            underrun    <= 1'b0;
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (blk_start) begin
                        state      <= S_PRE;
                        sd_dat_oe  <= 1'b1;
                        sd_dat_out <= 4'hF;
                        idle       <= 1'b0;
                        underrun   <= 1'b0;
                        crc        <= '0;
                    end
                end
                S_PRE: begin
                    state       <= S_START;
                    sd_dat_out  <= 4'h0;
                    wdata_ready <= 1'b1;
                end
                S_START, S_DATA: begin
                    if (state == S_DATA && nib == 2'd3 && last_word) begin
                        state      <= S_CRC;
                        sd_dat_out <= crc_msb;
                        crc        <= crc_shl;
                        cnt        <= '0;
                    end else begin
                        state      <= S_DATA;
                        sd_dat_out <= emit_nib;
                        crc        <= crc_nxt;
                        if (take_word) begin
                            shreg       <= {in_word[11:0], 4'h0};
                            word_idx    <= (state == S_START) ? '0 : word_idx + WORD_W'(1);
                            nib         <= 2'd0;
                            wdata_ready <= 1'b0;
                            if (!wdata_valid)
                                underrun <= 1'b1;
                        end else begin
                            shreg       <= {shreg[11:0], 4'h0};
                            nib         <= nib + 2'd1;
                            wdata_ready <= (nib == 2'd2) && !last_word;
                        end
                    end
                end
                S_CRC: begin
                    if (cnt == CNT_W'(15)) begin
                        state      <= S_END;
                        sd_dat_out <= 4'hF;
                    end else begin
                        sd_dat_out <= crc_msb;
                        crc        <= crc_shl;
                        cnt        <= cnt + CNT_W'(1);
                    end
                end
                S_END: begin
                    state     <= S_STAT;
                    sd_dat_oe <= 1'b0;
                    tok_ph    <= T_WAIT;
                    cnt       <= '0;
                end
                S_STAT: begin
                    case (tok_ph)
                        // Start bit may arrive on any of the STATUS_WAIT_CLKS cycles after END.
                        T_WAIT: begin
                            if (!sd_dat_in[0]) begin
                                tok_ph <= T_BITS;
                                cnt    <= '0;
                            end else if (cnt == CNT_W'(STATUS_WAIT_CLKS - 1)) begin
                                state  <= S_IDLE;
                                idle   <= 1'b1;
                                done   <= 1'b1;
                                status <= 3'b111;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        T_BITS: begin
                            tok <= {tok[1:0], sd_dat_in[0]};
                            cnt <= cnt + CNT_W'(1);
                            if (cnt == CNT_W'(2))
                                tok_ph <= T_END;
                        end
                        default: begin
                            if (sd_dat_in[0]) begin
                                state <= S_BUSY;
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
                                busy_cnt <= '0;
`endif
                            end else begin
                                state  <= S_IDLE;
                                idle   <= 1'b1;
                                done   <= 1'b1;
                                status <= 3'b111;
                            end
                        end
                    endcase
                end
                S_BUSY: begin
                    if (sd_dat_in[0]) begin
                        state  <= S_IDLE;
                        idle   <= 1'b1;
                        done   <= 1'b1;
                        status <= tok;
                    end
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
                    else if (busy_cnt == BUSY_W'(BUSY_TIMEOUT_CLKS - 1)) begin
                        state  <= S_IDLE;
                        idle   <= 1'b1;
                        done   <= 1'b1;
                        status <= 3'b111;
                    end else begin
                        busy_cnt <= busy_cnt + BUSY_W'(1);
                    end
`endif
                end
                default: begin
                    state     <= S_IDLE;
                    sd_dat_oe <= 1'b0;
                    idle      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_writer.sv
// Self-checking bench for sd_dat_writer: table of block scenarios, random blocks,
// and hand-written reset and back-to-back sequences against a card/CRC reference model.
`timescale 1ns/1ps
module tb_sd_dat_writer;

    localparam int BLK = 512;
    localparam int W   = BLK / 2;
    localparam int S   = 16;
    localparam int BT  = 64;
    localparam int LEN = 4 * W + 19;

    logic        clk = 1'b0;
    logic        rst_;
    logic        blk_start;
    logic [15:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [3:0]  sd_dat_out;
    logic        sd_dat_oe;
    logic [3:0]  sd_dat_in;
    logic        idle;
    logic        done;
    logic [2:0]  status;
    logic        underrun;

    int n_checks = 0;
    int n_pass   = 0;

    sd_dat_writer #(
        .BLOCK_LEN_BYTES(BLK), .STATUS_WAIT_CLKS(S), .BUSY_TIMEOUT_CLKS(BT)
    ) dut (
        .clk(clk), .rst_(rst_), .blk_start(blk_start), .wdata(wdata),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .sd_dat_out(sd_dat_out), .sd_dat_oe(sd_dat_oe), .sd_dat_in(sd_dat_in),
        .idle(idle), .done(done), .status(status), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pattern;     // 0 zeros, 1 FFFF/1234, 2 random
        int         gap;         // word index presented with wdata_valid=0, -1 none
        bit         token_en;    // card answers with a token at all
        logic [2:0] token;
        int         delay;       // idle DAT0 cycles after END before start bit
        int         busy;        // busy-low cycles after token end bit
        bit         bad_end;     // token end bit driven 0
        bit         mid_start;   // spurious blk_start during DATA
        logic [2:0] exp_status;
        bit         exp_underrun;
    } scen_t;

    localparam logic [2:0] LONG_BUSY_STATUS =
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
        3'b111;
`else
        3'b010;
`endif

    logic [3:0] pay [4*W];
    logic [3:0] expq [LEN];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // CRC as the remainder of payload(x)*x^16 divided by the generator polynomial.
    function automatic logic [15:0] crc_line(input int line);
        logic [16:0] r;
        r = '0;
        for (int i = 0; i < 4 * W + 16; i++) begin
            logic b;
            b = (i < 4 * W) ? pay[i][line] : 1'b0;
            r = {r[15:0], b};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    // Card behaviour on DAT0, rel = cycles after the END cycle.
    function automatic logic card_dat0(input int rel, input scen_t sc);
        if (!sc.token_en || rel <= sc.delay) return 1'b1;
        if (rel == sc.delay + 1) return 1'b0;
        if (rel <= sc.delay + 4) return sc.token[sc.delay + 4 - rel];
        if (rel == sc.delay + 5) return !sc.bad_end;
        if (rel <= sc.delay + 5 + sc.busy) return 1'b0;
        return 1'b1;
    endfunction

    // Cycle (relative to END) in which done is expected.
    function automatic int exp_done_rel(input scen_t sc);
        if (!sc.token_en) return S + 1;
        if (sc.bad_end) return sc.delay + 6;
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
        if (sc.busy >= BT) return sc.delay + 6 + BT;
`endif
        return sc.delay + 7 + sc.busy;
    endfunction

    function automatic logic [2:0] model_status(input scen_t sc);
        if (!sc.token_en || sc.bad_end) return 3'b111;
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
        if (sc.busy >= BT) return 3'b111;
`endif
        return sc.token;
    endfunction

    // Runs one block starting at the current negedge; returns at the negedge showing done.
    task automatic run_block(input scen_t sc, input string tag);
        logic [15:0] words [W];
        bit          vm [W];
        logic [15:0] lc [4];
        int k = 0, oe_cnt = 0, ready_cnt = 0, errs = 0, t0 = -1, done_rel = -1;
        int crc_or = 0;
        bit prev_oe = 1'b0, seen = 1'b0;
        logic [2:0] st_d = 3'b000;
        logic id_d = 1'b0, ur_d = 1'b0;

        for (int i = 0; i < W; i++) begin
            case (sc.pattern)
                0:       words[i] = 16'h0000;
                1:       words[i] = (i % 2 == 0) ? 16'hFFFF : 16'h1234;
                default: words[i] = 16'($urandom);
            endcase
            vm[i] = (i != sc.gap);
            for (int n = 0; n < 4; n++)
                pay[4*i+n] = vm[i] ? words[i][15-4*n -: 4] : 4'h0;
        end
        for (int l = 0; l < 4; l++) lc[l] = crc_line(l);
        expq[0] = 4'hF;
        expq[1] = 4'h0;
        for (int i = 0; i < 4 * W; i++) expq[2+i] = pay[i];
        for (int j = 0; j < 16; j++)
            expq[4*W+2+j] = {lc[3][15-j], lc[2][15-j], lc[1][15-j], lc[0][15-j]};
        expq[LEN-1] = 4'hF;

        blk_start   = 1'b1;
        wdata       = words[0];
        wdata_valid = vm[0];
        sd_dat_in   = 4'hF;
        for (int c = 1; c <= 4 * W + 700 && !seen; c++) begin
            @(negedge clk);
            blk_start = sc.mid_start && (c == 200);
            if (sd_dat_oe) begin
                if (oe_cnt < LEN && sd_dat_out !== expq[oe_cnt]) errs++;
                if (oe_cnt >= 4 * W + 2 && oe_cnt < 4 * W + 18) crc_or |= int'(sd_dat_out);
                oe_cnt++;
            end
            if (prev_oe && !sd_dat_oe) t0 = c - 1;
            prev_oe = sd_dat_oe;
            wdata       = words[(k < W) ? k : W - 1];
            wdata_valid = vm[(k < W) ? k : W - 1];
            if (wdata_ready) begin
                ready_cnt++;
                k++;
            end
            if (t0 >= 0) sd_dat_in = {3'b111, card_dat0(c - t0, sc)};
            if (done) begin
                seen = 1'b1;
                done_rel = (t0 >= 0) ? c - t0 : -1000;
                st_d = status;
                id_d = idle;
                ur_d = underrun;
            end
        end
        sd_dat_in = 4'hF;

        check({tag, " oe_cycles"}, oe_cnt, LEN);
        check({tag, " wrong_nibbles"}, errs, 0);
        check({tag, " ready_cycles"}, ready_cnt, W);
        check({tag, " done_seen"}, int'(seen), 1);
        check({tag, " done_after_end"}, done_rel, exp_done_rel(sc));
        check({tag, " status"}, int'(st_d), int'(sc.exp_status));
        check({tag, " idle_with_done"}, int'(id_d), 1);
        check({tag, " underrun"}, int'(ur_d), int'(sc.exp_underrun));
        if (sc.pattern == 0) check({tag, " crc_zero"}, crc_or, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        scen_t tbl [9];
        scen_t sc;
        logic [2:0] toks [3];
        toks[0] = 3'b010; toks[1] = 3'b101; toks[2] = 3'b110;

        //          pat gap  tok   token  dly bsy bad   mid   status  urun
        tbl[0] = '{0, -1,  1'b1, 3'b010, 2,  10,  1'b0, 1'b0, 3'b010, 1'b0};
        tbl[1] = '{1, -1,  1'b1, 3'b010, 2,  3,   1'b0, 1'b0, 3'b010, 1'b0};
        tbl[2] = '{1, 100, 1'b1, 3'b010, 2,  5,   1'b0, 1'b0, 3'b010, 1'b1};
        tbl[3] = '{1, -1,  1'b1, 3'b101, 0,  0,   1'b0, 1'b0, 3'b101, 1'b0};
        tbl[4] = '{2, -1,  1'b0, 3'b000, 0,  0,   1'b0, 1'b0, 3'b111, 1'b0};
        tbl[5] = '{2, -1,  1'b1, 3'b010, S-1, 4,  1'b0, 1'b0, 3'b010, 1'b0};
        tbl[6] = '{1, -1,  1'b1, 3'b010, 3,  0,   1'b1, 1'b0, 3'b111, 1'b0};
        tbl[7] = '{2, -1,  1'b1, 3'b110, 1,  2,   1'b0, 1'b1, 3'b110, 1'b0};
        tbl[8] = '{0, -1,  1'b1, 3'b010, 2,  300, 1'b0, 1'b0, LONG_BUSY_STATUS, 1'b0};

        rst_ = 1'b0; blk_start = 1'b0; wdata = '0; wdata_valid = 1'b0; sd_dat_in = 4'hF;
        repeat (3) @(negedge clk);
        check("reset oe", int'(sd_dat_oe), 0);
        check("reset out", int'(sd_dat_out), 15);
        check("reset ready", int'(wdata_ready), 0);
        check("reset idle", int'(idle), 1);
        check("reset done", int'(done), 0);
        check("reset status", int'(status), 0);
        check("reset underrun", int'(underrun), 0);
        rst_ = 1'b1;
        @(negedge clk);

        // Table blocks run back-to-back: each starts in the cycle that showed done.
        for (int t = 0; t < 9; t++) run_block(tbl[t], $sformatf("tbl%0d", t));
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);

        for (int r = 0; r < 4; r++) begin
            sc.pattern   = 2;
            sc.gap       = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
            sc.token_en  = 1'b1;
            sc.token     = toks[$urandom_range(0, 2)];
            sc.delay     = int'($urandom_range(0, S - 1));
            sc.busy      = int'($urandom_range(0, 20));
            sc.bad_end   = 1'b0;
            sc.mid_start = ($urandom_range(0, 1) == 1);
            sc.exp_status   = model_status(sc);
            sc.exp_underrun = (sc.gap >= 0);
            run_block(sc, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of DATA releases the bus without waiting for a clock.
        @(negedge clk);
        blk_start = 1'b1; wdata = 16'hA5A5; wdata_valid = 1'b1;
        @(negedge clk);
        blk_start = 1'b0;
        repeat (50) @(negedge clk);
        check("mid oe_before_reset", int'(sd_dat_oe), 1);
        #2 rst_ = 1'b0;
        #1;
        check("async_rst oe", int'(sd_dat_oe), 0);
        check("async_rst idle", int'(idle), 1);
        check("async_rst ready", int'(wdata_ready), 0);
        check("async_rst out", int'(sd_dat_out), 15);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        run_block(tbl[1], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
